// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_param
// Purpose  : Parametrised single-clock FIFO with occupancy count, almost flags
//            and sticky overflow/underflow errors.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   we,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   re,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       data,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  localparam logic [c_cw-1:0] c_depth     = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_afull_th  = c_cw'(AFULL_TH);
  localparam logic [c_cw-1:0] c_aempty_th = c_cw'(AEMPTY_TH);
  localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);
  localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic             w_wr_ok;
  logic             w_rd_ok;

  // At full a simultaneous read frees the slot the write lands in.
  assign w_wr_ok = we && (!full || re);
  assign w_rd_ok = re && !empty;

  assign full         = (count == c_depth);
  assign empty        = (count == '0);
  assign almost_full  = (count >= c_afull_th);
  assign almost_empty = (count <= c_aempty_th);

  // Storage carries no reset; contents are meaningless once count is zero.
  always_ff @(posedge clock) begin
    if (reset && w_wr_ok) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      count     <= '0;
      data      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + c_ptr_one;
      end

      if (w_rd_ok) begin
        data   <= r_mem[r_rptr];
        r_rptr <= r_rptr + c_ptr_one;
      end

      case ({w_wr_ok, w_rd_ok})
        2'b10:   count <= count + c_cnt_one;
        2'b01:   count <= count - c_cnt_one;
        default: count <= count;
      endcase

      // A new error event takes priority over a same-cycle clear.
      if (we && !w_wr_ok) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end

      if (re && !w_rd_ok) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync_param
// Purpose  : Directed scoreboard bench for fifo_sync_param (DEPTH=16, WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_param;

  localparam int c_width = 8;
  localparam int c_depth = 16;

  localparam int c_sel_data = 0;
  localparam int c_sel_cnt  = 1;
  localparam int c_sel_full = 2;
  localparam int c_sel_emp  = 3;
  localparam int c_sel_af   = 4;
  localparam int c_sel_ae   = 5;
  localparam int c_sel_ovf  = 6;
  localparam int c_sel_unf  = 7;

  logic               clock   = 1'b0;
  logic               reset   = 1'b0;
  logic               we      = 1'b0;
  logic [c_width-1:0] wr_data = '0;
  logic               re      = 1'b0;
  logic               clr_err = 1'b0;
  logic [c_width-1:0] data;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [4:0]         count;
  logic               overflow;
  logic               underflow;

  fifo_sync_param #(
    .WIDTH    (c_width),
    .DEPTH    (c_depth),
    .AFULL_TH (14),
    .AEMPTY_TH(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .we          (we),
    .wr_data     (wr_data),
    .re          (re),
    .clr_err     (clr_err),
    .data        (data),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [7:0]  val;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned ncyc    = 0;
  int unsigned tgt     = 0;
  int          n_pass  = 0;
  int          n_total = 0;

  function automatic logic [7:0] actual(input int sel);
    case (sel)
      c_sel_data: return data;
      c_sel_cnt:  return {3'b000, count};
      c_sel_full: return {7'b0, full};
      c_sel_emp:  return {7'b0, empty};
      c_sel_af:   return {7'b0, almost_full};
      c_sel_ae:   return {7'b0, almost_empty};
      c_sel_ovf:  return {7'b0, overflow};
      default:    return {7'b0, underflow};
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, expv, $time);
  endtask

  // One bus cycle: inputs change just after a falling edge, are sampled on
  // the next rising edge, and their effect is checked on the falling edge after.
  task automatic step(input logic w, input logic [7:0] wd, input logic r, input logic c);
    @(negedge clock);
    #1;
    we = w; wr_data = wd; re = r; clr_err = c;
    tgt = ncyc + 1;
  endtask

  task automatic expect_at(input int sel, input int val, input string name);
    sb_q.push_back('{tgt, sel, 8'(val), name});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data"},  data,                 8'h00);
    check({tag, "_count"}, {3'b000, count},      8'd0);
    check({tag, "_empty"}, {7'b0, empty},        8'd1);
    check({tag, "_full"},  {7'b0, full},         8'd0);
    check({tag, "_ae"},    {7'b0, almost_empty}, 8'd1);
    check({tag, "_af"},    {7'b0, almost_full},  8'd0);
    check({tag, "_ovf"},   {7'b0, overflow},     8'd0);
    check({tag, "_unf"},   {7'b0, underflow},    8'd0);
  endtask

  // Monitor: retires every expectation due on this falling edge.
  initial begin
    forever begin
      @(negedge clock);
      ncyc++;
      while (sb_q.size() > 0 && sb_q[0].cyc <= ncyc) begin
        mon_e = sb_q.pop_front();
        check(mon_e.name, actual(mon_e.sel), mon_e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #7;
    check_reset_state("por");
    @(negedge clock); #1;
    reset = 1'b1;

    // Fill 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      expect_at(c_sel_cnt, i, "fill_count");
      if (i == 1)  expect_at(c_sel_emp, 0, "fill_empty_drop");
      if (i == 2)  expect_at(c_sel_ae, 1, "fill_ae_at2");
      if (i == 3)  expect_at(c_sel_ae, 0, "fill_ae_at3");
      if (i == 13) expect_at(c_sel_af, 0, "fill_af_at13");
      if (i == 14) expect_at(c_sel_af, 1, "fill_af_at14");
      if (i == 15) expect_at(c_sel_full, 0, "fill_full_at15");
      if (i == 16) expect_at(c_sel_full, 1, "fill_full_at16");
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    expect_at(c_sel_ovf, 1, "ovf_set");
    expect_at(c_sel_cnt, 16, "ovf_count");
    expect_at(c_sel_full, 1, "ovf_full");

    // Drain in order; the dropped 0xFF must never appear.
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      expect_at(c_sel_data, i, "drain_data");
      expect_at(c_sel_cnt, 16 - i, "drain_count");
      if (i == 2)  expect_at(c_sel_af, 1, "drain_af_at14");
      if (i == 3)  expect_at(c_sel_af, 0, "drain_af_at13");
      if (i == 13) expect_at(c_sel_ae, 0, "drain_ae_at3");
      if (i == 14) expect_at(c_sel_ae, 1, "drain_ae_at2");
      if (i == 16) expect_at(c_sel_emp, 1, "drain_empty");
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    expect_at(c_sel_unf, 1, "unf_set");
    expect_at(c_sel_data, 8'h10, "unf_data_hold");
    expect_at(c_sel_cnt, 0, "unf_count");

    step(1'b0, 8'h00, 1'b0, 1'b1);
    expect_at(c_sel_ovf, 0, "clr_ovf");
    expect_at(c_sel_unf, 0, "clr_unf");

    // Simultaneous read/write at full.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    expect_at(c_sel_data, 8'h20, "full_rw_data");
    expect_at(c_sel_cnt, 16, "full_rw_count");
    expect_at(c_sel_ovf, 0, "full_rw_ovf");
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      expect_at(c_sel_data, 8'h20 + i, "full_rw_drain");
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    expect_at(c_sel_data, 8'hAA, "full_rw_last");
    expect_at(c_sel_cnt, 0, "full_rw_end_count");

    // Simultaneous read/write at empty.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    expect_at(c_sel_cnt, 1, "empty_rw_count");
    expect_at(c_sel_unf, 1, "empty_rw_unf");
    expect_at(c_sel_data, 8'hAA, "empty_rw_data_hold");
    step(1'b0, 8'h00, 1'b1, 1'b0);
    expect_at(c_sel_data, 8'h55, "empty_rw_next");
    expect_at(c_sel_cnt, 0, "empty_rw_next_count");

    // Error event in the same cycle as clear keeps the flag set.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    expect_at(c_sel_unf, 1, "clr_vs_event");

    // Wrap-around: pointers pass 15 during the second burst.
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      expect_at(c_sel_data, 8'h30 + i, "wrap1_data");
    end
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    expect_at(c_sel_cnt, 12, "wrap2_count_full");
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      expect_at(c_sel_data, 8'h40 + i, "wrap2_data");
    end
    expect_at(c_sel_cnt, 0, "wrap2_count_end");
    step(1'b0, 8'h00, 1'b0, 1'b1);
    expect_at(c_sel_ovf, 0, "wrap_clr_ovf");
    expect_at(c_sel_unf, 0, "wrap_clr_unf");

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    expect_at(c_sel_cnt, 7, "pre_reset_count");
    @(negedge clock); #1;
    we = 1'b1; wr_data = 8'h67; re = 1'b0; clr_err = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("async");
    we = 1'b0;
    @(negedge clock); #1;
    reset = 1'b1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    expect_at(c_sel_cnt, 1, "post_reset_count");
    step(1'b0, 8'h00, 1'b1, 1'b0);
    expect_at(c_sel_data, 8'h77, "post_reset_data");
    expect_at(c_sel_emp, 1, "post_reset_empty");
    step(1'b0, 8'h00, 1'b0, 1'b0);

    repeat (3) @(negedge clock);
    #1;
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO; the next generation of the team's fixed 16x8 buffer. It is generalised in data width and depth. It adds occupancy count, programmable almost-full/almost-empty flags, defined simultaneous read/write at the full and empty boundaries, and sticky overflow/underflow error flags with synchronous clear. It sits between a producer and a consumer in the same clock domain.

## Interface
- `WIDTH`, 8, data word width in bits (>=1)
- `DEPTH`, 16, number of entries; power of 2, >=4
- `AFULL_TH`, DEPTH-2, almost_full asserts when count >= AFULL_TH
- `AEMPTY_TH`, 2, almost_empty asserts when count <= AEMPTY_TH
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `we`  in  1  write request
- `wr_data`  in  WIDTH  write data, sampled with we
- `re`  in  1  read request
- `clr_err`  in  1  synchronous clear of overflow/underflow
- `data`  out  WIDTH  registered read data
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `almost_full`  out  1  count >= AFULL_TH
- `almost_empty`  out  1  count <= AEMPTY_TH
- `count`  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `overflow`  out  1  sticky: a write was dropped
- `underflow`  out  1  sticky: a read was refused

## Operation
- Storage: DEPTH x WIDTH array, not reset. Write pointer and read pointer are each clog2(DEPTH) bits and wrap modulo DEPTH with no gap. count is a separate register.
- Accepted write (`wr_ok`): we && (!full || re). The array is written at wptr, and wptr increments.
- Accepted read (`rd_ok`): re && !empty. The array entry at rptr is loaded into `data`, and rptr increments. `data` holds its value when there is no accepted read.
- count update:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged when both or neither
- Boundary rules:
  - Full, we && re: both are accepted. count stays DEPTH. The oldest word is output, and the new word is stored in the freed slot. overflow is not set.
  - Empty, we && re: the write is accepted and the read is refused. `data` is unchanged. count becomes 1, and underflow is set.
  - Full, we && !re: the write is dropped. Memory and pointers are unchanged, and overflow is set.
  - Empty, re && !we: the read is refused, and underflow is set.
- Flags:
  - full, empty, almost_full and almost_empty are decoded from registered count.
  - They are valid in the same cycle count updates.
  - No flag is decoded combinationally from we or re.
- Errors: overflow and underflow stay set until clr_err. If clr_err and a new error event occur in the same cycle, the flag stays set (the event wins).
- Reset (reset low, asynchronous): wptr=0, rptr=0, count=0, data=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Reset asserted mid-operation discards all contents immediately. Release is sampled on the next rising clock edge.

## Timing
- Write-to-empty-deassert latency: 1 cycle. The edge that samples we raises count, so empty falls after that edge.
- Read latency: 1 cycle. `data` shows the word on the edge that samples re.
- Minimum latency from a write to that word on `data`: 2 edges (write edge, then read edge).
- Sustained throughput is 1 write and 1 read per cycle, including at full.
- All outputs change only on a rising clock edge or on the asynchronous reset assertion.

## Test plan
- Reset, then write 16 words (0x01..0x10), one per cycle, with DEPTH=16 -> after the 16th write: full=1, count=16, almost_full=1 (from count 14). A 17th write of 0xFF -> overflow=1, count=16, contents unchanged.
- From full, issue 16 reads -> data returns 0x01..0x10 in order, each one cycle after its re edge. Then empty=1, count=0, almost_empty=1 (from count 2). A 17th read -> underflow=1 and data stays 0x10.
- Full FIFO, we=1 and re=1 with wr_data=0xAA for one cycle -> data=oldest word, count=16, overflow=0. A full drain then ends with 0xAA.
- Empty FIFO, we=1 and re=1 with wr_data=0x55 -> count=1, underflow=1, data unchanged. The next read returns 0x55.
- Wrap-around: 10 writes, 10 reads, then 12 writes and 12 reads -> all 12 words return in order, pointers wrap past 15, count returns to 0. Pulse clr_err -> overflow=0 and underflow=0.
- Reset asserted asynchronously mid-burst at count=7 -> all outputs take their reset values immediately, without a clock edge. After release, a write then a read returns the new word.
